kyber_stream_out: RTL
=====================

Name: kyber_stream_out

Overview:
- Downstream serializer for the coder's packed outputs (pk_out, sk_out, c_out, m_out).
- Captures one packed byte-string image on start and streams it as 32-bit words over a valid/ready handshake to the host/IO interface.
- Provides a done pulse for the top-level controller.

Parameters:
- DATA_W, 32, output word width in bits; fixed at 32.
- IMG_W, 6400, width of the input image bus in bits; the largest message is pk.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle request to capture img_in and begin streaming; honoured only in IDLE
- abort  input  1  synchronous cancel; returns the block to IDLE
- sel  input  2  message select: 0=pk (200 words), 1=sk (192 words), 2=c (192 words), 3=m (8 words)
- img_in  input  IMG_W  packed image; an N-word message occupies img_in[N*32-1:0]
- tready  input  1  sink ready
- tdata  output  DATA_W  current word
- tvalid  output  1  tdata valid
- tlast  output  1  high with the final word of the message
- busy  output  1  high in SEND and DONE
- done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset values: tdata=0, tvalid=0, tlast=0, busy=0, done=0, state=IDLE, word counter=0.
- Word count N from sel: 200, 192, 192, 8.
- Emission order: most significant word of the message first.
  - Word k (k=0..N-1) = img_in[(N-k)*32-1 -: 32] as captured at start.
  - For pk this gives t first, then rho in the last 8 words.
- Capture: on an accepted start, img_in is left-aligned into a 6400-bit shift register (shifted left by IMG_W-N*32). tdata is always the top 32 bits of that register.
- FSM states: IDLE, SEND, DONE.
  - IDLE: when start=1 and abort=0, load the register, set remaining=N-1, go to SEND. tvalid=1 in the next cycle, i.e. 1 cycle start-to-first-word latency.
  - SEND: tvalid=1. A handshake is tvalid&tready.
    - On a handshake with remaining>0: shift register left by 32, decrement remaining.
    - On a handshake with remaining==0: go to DONE.
  - DONE: tvalid=0, done=1 for exactly one cycle, busy=1, then IDLE.
- tlast = (state==SEND) && remaining==0.
- While tvalid=1 and tready=0, tdata and tlast are held stable; tvalid never drops before the handshake.
- Back-to-back tready=1 gives one word per cycle. An N-word message completes N+1 cycles after the first tvalid, with done in the (N+1)th cycle.
- start outside IDLE (SEND or DONE) is ignored; img_in is not re-sampled.
- abort:
  - In any state, next state is IDLE and tvalid, tlast and busy clear next cycle; no done pulse.
  - abort together with start in IDLE: abort wins, nothing is captured.
  - abort coincident with the final handshake: the word counts as transferred, but the state goes to IDLE and no done pulse is issued.
- Asynchronous rst mid-stream: all outputs return to reset values immediately; the partial message is discarded.
- sel is sampled only with an accepted start; changes during SEND have no effect.
- tdata is don't-care when tvalid=0 but is driven to 0 in IDLE.

Optional Feature:
- Macro KYBER_STREAM_BSWAP_EN.
- Defined: each emitted word is byte-reversed (tdata[7:0] = word[31:24], …) for little-endian host buses. Ordering, counts and handshake are unchanged.
- Undefined: words are emitted as-is, with the MSB byte in tdata[31:24].

Test Plan:
- sel=3, img_in[255:0]=0x0001…1F byte ramp, tready=1 -> 8 words, first tdata=0x00010203, last=0x1C1D1E1F with tlast=1, done pulse 9 cycles after the first tvalid.
- sel=0, img_in = word index pattern (word j = j), tready=1 -> 200 words, values 199 down to 0, tlast only on the 200th word, busy high for 201 cycles.
- sel=2, tready toggled in a 1-0-0 pattern -> tdata and tlast stable through stalls, exactly 192 handshakes, no dropped or duplicated words.
- start pulsed again mid-SEND with different img_in -> ignored; stream continues with the originally captured data.
- abort at word 5 of pk -> tvalid low next cycle, no done pulse; a new start with sel=3 then streams m correctly from word 0.
- rst asserted mid-stream -> tvalid, busy and done are 0 immediately; with KYBER_STREAM_BSWAP_EN defined, the m test's first word = 0x03020100.

Source files
------------

// File: rtl/kyber_stream_out.sv
// Serializes a captured packed Kyber message (pk/sk/c/m) into 32-bit valid/ready words, MS word first.
// Optional macro KYBER_STREAM_BSWAP_EN byte-reverses every emitted word for little-endian hosts.
`timescale 1ns/1ps
module kyber_stream_out #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 6400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        sel,
  input  logic [IMG_W-1:0]  img_in,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = 8;
  localparam int SH_PK = IMG_W - 200 * DATA_W;
  localparam int SH_SK = IMG_W - 192 * DATA_W;
  localparam int SH_M  = IMG_W - 8 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IMG_W-1:0]  sreg_q, sreg_d;
  logic              load;
  logic              hs;
  logic [DATA_W-1:0] word;

  // Index of the final word, i.e. word count minus one.
  function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] s);
    case (s)
      2'd0:    return CNT_W'(199);
      2'd1:    return CNT_W'(191);
      2'd2:    return CNT_W'(191);
      default: return CNT_W'(7);
    endcase
  endfunction

  // Constant shifts per message keep this a 4-way mux instead of a barrel shifter.
  function automatic logic [IMG_W-1:0] left_align(input logic [IMG_W-1:0] img,
                                                  input logic [1:0]       s);
    case (s)
      2'd0:    return img << SH_PK;
      2'd1:    return img << SH_SK;
      2'd2:    return img << SH_SK;
      default: return img << SH_M;
    endcase
  endfunction

`ifdef KYBER_STREAM_BSWAP_EN
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction
`endif

  assign load = (state_q == S_IDLE) && start && !abort;
  assign hs   = (state_q == S_SEND) && tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Payload register carries no reset; it is only observed while in SEND.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SEND;
          rem_d   = last_idx(sel);
          sreg_d  = left_align(img_in, sel);
        end
      end
      S_SEND: begin
        if (hs) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d  = rem_q - CNT_W'(1);
            sreg_d = sreg_q << DATA_W;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Cancel overrides everything, including a final handshake, so no done is raised.
    if (abort) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end
  end

`ifdef KYBER_STREAM_BSWAP_EN
  assign word = byte_swap(sreg_q[IMG_W-1 -: DATA_W]);
`else
  assign word = sreg_q[IMG_W-1 -: DATA_W];
`endif

  always_comb begin
    tvalid = 1'b0;
    tlast  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    tdata  = '0;
    unique case (state_q)
      S_SEND: begin
        tvalid = 1'b1;
        tlast  = (rem_q == '0);
        busy   = 1'b1;
        tdata  = word;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
